// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_arb_pkg: shared types and widths for the I2C bus arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package i2c_arb_pkg;

  localparam int DEV_AW = 7;
  localparam int REG_AW = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick: combinational round-robin selector, search starts at last+1
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    logic [31:0]   w_sum;
    logic [IW-1:0] w_cand;
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum  = (32'(last) + 32'(k)) % 32'(NREQ);
      w_cand = IW'(w_sum);
      if (!any && req[w_cand]) begin
        any         = 1'b1;
        idx         = w_cand;
        gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_bus_arbiter: round-robin sharing of one read-2-bytes I2C master
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [DEV_AW*NREQ-1:0]   req_dev_addr,
  input  logic [REG_AW*NREQ-1:0]   req_reg_addr,
  output logic [NREQ-1:0]          req_grant,
  output logic [NREQ-1:0]          req_done,
  output logic [NREQ-1:0]          req_err,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     m_start,
  output logic [DEV_AW-1:0]        m_dev_addr,
  output logic [REG_AW-1:0]        m_reg_addr,
  input  logic                     m_busy,
  input  logic                     m_done,
  input  logic [DATA_W-1:0]        m_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_owner;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req  (req_valid),
    .last (r_last),
    .gnt  (w_gnt),
    .idx  (w_idx),
    .any  (w_any)
  );

  // Decoded from state so the start pulse lands in the same cycle the grant appears.
  assign m_start = (r_state == ST_ISSUE) && !m_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_last     <= IW'(NREQ - 1);
      r_owner    <= '0;
      req_grant  <= '0;
      req_done   <= '0;
      req_err    <= '0;
      rsp_data   <= '0;
      m_dev_addr <= '0;
      m_reg_addr <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            req_grant  <= w_gnt;
            r_owner    <= w_idx;
            m_dev_addr <= req_dev_addr[w_idx*DEV_AW +: DEV_AW];
            m_reg_addr <= req_reg_addr[w_idx*REG_AW +: REG_AW];
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!m_busy) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // Completion takes priority over a timeout falling in the same cycle.
          if (m_done) begin
            rsp_data <= m_data;
            req_done <= req_grant;
            r_state  <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            req_err <= req_grant;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_last    <= r_owner;
          req_grant <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_bus_arbiter: directed and randomized transactions vs. a transaction model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [7*NREQ-1:0] req_dev_addr = '0;
  logic [8*NREQ-1:0] req_reg_addr = '0;
  logic [NREQ-1:0]   req_grant, req_done, req_err;
  logic [15:0]       rsp_data;
  logic              m_start;
  logic [6:0]        m_dev_addr;
  logic [7:0]        m_reg_addr;
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic [15:0]       m_data = '0;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_start = 0;
  int          mdl_last = NREQ - 1;
  logic [15:0] mdl_rsp = '0;
  int          age [NREQ];

  i2c_bus_arbiter #(
    .NREQ           (NREQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_dev_addr (req_dev_addr),
    .req_reg_addr (req_reg_addr),
    .req_grant    (req_grant),
    .req_done     (req_done),
    .req_err      (req_err),
    .rsp_data     (rsp_data),
    .m_start      (m_start),
    .m_dev_addr   (m_dev_addr),
    .m_reg_addr   (m_reg_addr),
    .m_busy       (m_busy),
    .m_done       (m_done),
    .m_data       (m_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (m_start) n_start++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Owner choice: first requester found walking upward from the one served last.
  function automatic int mdl_pick(input logic [NREQ-1:0] rv, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (rv[(last + k) % NREQ]) return (last + k) % NREQ;
    return 0;
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_grant"}, 32'(req_grant), 32'd0);
    check_eq({tag, "_pulse"}, 32'({req_done, req_err}), 32'd0);
    check_eq({tag, "_start"}, 32'(m_start), 32'd0);
    check_eq({tag, "_rsp"}, 32'(rsp_data), 32'd0);
    check_eq({tag, "_dev"}, 32'(m_dev_addr), 32'd0);
    check_eq({tag, "_reg"}, 32'(m_reg_addr), 32'd0);
  endtask

  // One complete transaction, entered at the negedge before the granting edge.
  task automatic txn(input int busy_n, input int delay, input logic [15:0] data,
                     input logic [NREQ-1:0] next_rv, input bit stray, input bit scramble);
    int              own;
    int              s0;
    int              last_k;
    bit              ok_done;
    logic [NREQ-1:0] oh;
    logic [6:0]      edev;
    logic [7:0]      ereg;
    own  = mdl_pick(req_valid, mdl_last);
    oh   = NREQ'(1) << own;
    edev = req_dev_addr[own*7 +: 7];
    ereg = req_reg_addr[own*8 +: 8];
    check_eq("starve_age_ok", 32'(age[own] <= NREQ - 1), 32'd1);
    for (int i = 0; i < NREQ; i++) begin
      if (i == own) age[i] = 0;
      else if (req_valid[i]) age[i]++;
    end
    s0 = n_start;
    for (int b = 0; b <= busy_n; b++) begin
      @(negedge clk);
      m_busy = (b < busy_n);
      m_done = 1'b0;
      #1;
      check_eq("grant", 32'(req_grant), 32'(oh));
      check_eq("issue_dev", 32'(m_dev_addr), 32'(edev));
      check_eq("issue_reg", 32'(m_reg_addr), 32'(ereg));
      check_eq("start", 32'(m_start), 32'(!m_busy));
      check_eq("rsp_hold", 32'(rsp_data), 32'(mdl_rsp));
      check_eq("issue_pulse", 32'({req_done, req_err}), 32'd0);
    end
    ok_done = (delay <= TMO);
    last_k  = ok_done ? delay : TMO;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      m_done = ok_done && (k == last_k);
      m_data = m_done ? data : 16'($urandom);
      m_busy = 1'($urandom);
      if ($urandom_range(0, 7) == 0) req_valid[own] = 1'b0;
      req_dev_addr[own*7 +: 7] = 7'($urandom);
      req_reg_addr[own*8 +: 8] = 8'($urandom);
      #1;
      check_eq("wait_pulse", 32'({req_done, req_err}), 32'd0);
      check_eq("wait_grant", 32'(req_grant), 32'(oh));
      check_eq("wait_dev", 32'(m_dev_addr), 32'(edev));
      check_eq("wait_reg", 32'(m_reg_addr), 32'(ereg));
    end
    @(negedge clk);
    m_done = 1'b0;
    m_busy = 1'b0;
    #1;
    if (ok_done) mdl_rsp = data;
    check_eq("done", 32'(req_done), ok_done ? 32'(oh) : 32'd0);
    check_eq("err", 32'(req_err), ok_done ? 32'd0 : 32'(oh));
    check_eq("rsp", 32'(rsp_data), 32'(mdl_rsp));
    check_eq("one_start", 32'(n_start - s0), 32'd1);
    mdl_last  = own;
    req_valid = next_rv;
    if (scramble) begin
      req_dev_addr = 28'($urandom);
      req_reg_addr = 32'($urandom);
    end
    @(negedge clk);
    m_done = stray;
    m_data = 16'($urandom);
    #1;
    check_eq("idle_grant", 32'(req_grant), 32'd0);
    check_eq("idle_pulse", 32'({req_done, req_err}), 32'd0);
    check_eq("idle_start", 32'(m_start), 32'd0);
  endtask

  initial begin
    int              own;
    int              d;
    int              sel;
    logic [NREQ-1:0] nx;
    for (int i = 0; i < NREQ; i++) age[i] = 0;
    req_valid              = 4'b1111;
    req_dev_addr           = 28'h3f5_a6c4;
    req_reg_addr           = 32'h8877_6655;
    req_dev_addr[6:0]      = 7'h29;
    req_reg_addr[7:0]      = 8'h96;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;

    // contention: 0,1,2,3,0 with all four held
    for (int t = 0; t < 4; t++) txn(t % 2, 3 + t, 16'(16'h1000 + t), 4'b1111, 1'b0, 1'b0);
    txn(0, 5, 16'h2222, 4'b0001, 1'b0, 1'b0);

    // single request, then timeout, then done coincident with timeout
    txn(0, 50, 16'h1234, 4'b0001, 1'b1, 1'b0);
    txn(0, TMO + 10, 16'hdead, 4'b0001, 1'b1, 1'b0);
    txn(0, TMO, 16'hbeef, 4'b0100, 1'b1, 1'b0);

    // master busy for 10 cycles after grant
    txn(10, 7, 16'h5a5a, 4'b0010, 1'b0, 1'b0);

    // reset in the middle of a wait, requester 1 still pending
    @(negedge clk);
    m_busy = 1'b0;
    m_done = 1'b0;
    #1;
    check_eq("pre_rst_grant", 32'(req_grant), 32'b0010);
    check_eq("pre_rst_start", 32'(m_start), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_state("async_rst");
    repeat (2) begin
      @(negedge clk);
      #1;
      check_eq("rst_hold_pulse", 32'({req_done, req_err}), 32'd0);
    end
    @(negedge clk);
    rst      = 1'b1;
    mdl_last = NREQ - 1;
    mdl_rsp  = '0;
    for (int i = 0; i < NREQ; i++) age[i] = 0;
    txn(0, 4, 16'hc0de, 4'b1011, 1'b0, 1'b1);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      own = mdl_pick(req_valid, mdl_last);
      nx  = (req_valid & ~(NREQ'(1) << own)) | NREQ'($urandom);
      if (nx == '0) nx = NREQ'(1) << $urandom_range(0, NREQ - 1);
      sel = int'($urandom_range(0, 9));
      d   = (sel == 0) ? TMO : (sel == 1) ? TMO + 1 + int'($urandom_range(0, 5))
                                          : int'($urandom_range(1, 40));
      txn(int'($urandom_range(0, 3)), d, 16'($urandom), nx, 1'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
